// File: rtl/simd_mac_acc_if.sv
// simd_mac_acc_if: input beat handshake, vector operands and result bundle.
interface simd_mac_acc_if #(parameter int BW = 8, parameter int LANES = 4, parameter int ACC_W = 20);
    logic                   in_valid;
    logic                   in_ready;
    logic [1:0]             mode;
    logic                   acc_clr;
    logic [LANES*BW-1:0]    din_a;
    logic [LANES*BW-1:0]    din_b;
    logic [LANES*BW-1:0]    din_c;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*ACC_W-1:0] dout;
    logic [LANES-1:0]       ovf;
    modport master(output in_valid, mode, acc_clr, din_a, din_b, din_c, out_ready,
                   input in_ready, out_valid, dout, ovf);
    modport slave(input in_valid, mode, acc_clr, din_a, din_b, din_c, out_ready,
                  output in_ready, out_valid, dout, ovf);
endinterface

// File: rtl/simd_mac_acc.sv
// simd_mac_acc: two-stage SIMD multiply-add with per-lane accumulators and sticky overflow.
module simd_mac_acc #(
    parameter int BW    = 8,
    parameter int LANES = 4,
    parameter int ACC_W = 20,
    parameter int SAT   = 1
) (
    input logic            clk,
    input logic            rst,
    simd_mac_acc_if.slave  bus
);
    logic                   en;
    logic                   v1_q, v1_d, clr1_q, clr1_d, out_valid_q, out_valid_d;
    logic [1:0]             mode1_q, mode1_d;
    logic [LANES*BW-1:0]    a1_q, a1_d, b1_q, b1_d, c1_q, c1_d;
    logic [LANES*2*BW-1:0]  p1_q, p1_d, prod;
    logic [LANES*ACC_W-1:0] dout_q, dout_d, acc_q, acc_d, lane_res;
    logic [LANES-1:0]       ovf_q, ovf_d, lane_ovf;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [BW-1:0]    a, b, c;
        logic [2*BW-1:0]  p;
        logic [ACC_W-1:0] base;
        logic [ACC_W:0]   sum;
        assign prod[i*2*BW +: 2*BW] = (2*BW)'(bus.din_a[i*BW +: BW]) * (2*BW)'(bus.din_b[i*BW +: BW]);
        assign a    = a1_q[i*BW +: BW];
        assign b    = b1_q[i*BW +: BW];
        assign c    = c1_q[i*BW +: BW];
        assign p    = p1_q[i*2*BW +: 2*BW];
        assign base = clr1_q ? '0 : acc_q[i*ACC_W +: ACC_W];
        assign sum  = {1'b0, base} + (ACC_W+1)'(p);
        assign lane_ovf[i] = sum[ACC_W];
        assign lane_res[i*ACC_W +: ACC_W] =
            mode1_q == 2'b00 ? ACC_W'(a) + ACC_W'(b) :
            mode1_q == 2'b01 ? ACC_W'(p) + ACC_W'(c) :
            mode1_q == 2'b10 ? ACC_W'(p) :
            (sum[ACC_W] && SAT != 0) ? '1 : sum[ACC_W-1:0];
    end

    always_comb begin
        en          = !out_valid_q || bus.out_ready;
        v1_d        = v1_q;
        mode1_d     = mode1_q;
        clr1_d      = clr1_q;
        a1_d        = a1_q;
        b1_d        = b1_q;
        c1_d        = c1_q;
        p1_d        = p1_q;
        out_valid_d = out_valid_q;
        dout_d      = dout_q;
        acc_d       = acc_q;
        ovf_d       = ovf_q;
        if (en) begin
            v1_d        = bus.in_valid;
            mode1_d     = bus.mode;
            clr1_d      = bus.acc_clr;
            a1_d        = bus.din_a;
            b1_d        = bus.din_b;
            c1_d        = bus.din_c;
            p1_d        = prod;
            out_valid_d = v1_q;
            dout_d      = v1_q ? lane_res : dout_q;
            // Only a real accumulate beat leaving S1 may touch acc/ovf; bubbles keep them.
            if (v1_q && mode1_q == 2'b11) begin
                acc_d = lane_res;
                ovf_d = (clr1_q ? '0 : ovf_q) | lane_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q        <= 1'b0;
            mode1_q     <= '0;
            clr1_q      <= 1'b0;
            a1_q        <= '0;
            b1_q        <= '0;
            c1_q        <= '0;
            p1_q        <= '0;
            out_valid_q <= 1'b0;
            dout_q      <= '0;
            acc_q       <= '0;
            ovf_q       <= '0;
        end else begin
            v1_q        <= v1_d;
            mode1_q     <= mode1_d;
            clr1_q      <= clr1_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            c1_q        <= c1_d;
            p1_q        <= p1_d;
            out_valid_q <= out_valid_d;
            dout_q      <= dout_d;
            acc_q       <= acc_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
endmodule
